// File: rtl/muldiv_if.sv
// Handshake and data bundle between the EX stage and the multi-cycle M-extension unit.
`timescale 1ns/1ps
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            abort;
  logic [4:0]      select;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            valid;

  // Pipeline side issues operations and consumes results.
  modport master (
    output start, abort, select, data1, data2,
    input  result, busy, valid
  );

  // Execute unit side.
  modport slave (
    input  start, abort, select, data1, data2,
    output result, busy, valid
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: registered multiply, iterative radix-2
// restoring divide, start/busy/valid handshake with abort.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic     clk,
  input  logic     reset,   // synchronous, active-low
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   MUL_CNT_INIT = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0]   DIV_CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG     = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Decode of the incoming request (only meaningful while idle/done).
  logic in_mul, in_div, in_signed, in_quo, in_zero, in_ovf, in_idle;
  assign in_mul    = (bus.select >= OP_MUL) && (bus.select <= OP_MULHU);
  assign in_div    = (bus.select >= OP_DIV) && (bus.select <= OP_REMU);
  assign in_signed = (bus.select == OP_DIV) || (bus.select == OP_REM);
  assign in_quo    = (bus.select == OP_DIV) || (bus.select == OP_DIVU);
  assign in_zero   = (bus.data2 == '0);
  assign in_ovf    = in_signed && (bus.data1 == MOST_NEG) && (bus.data2 == '1);
  assign in_idle   = (state_q == S_IDLE) || (state_q == S_DONE);

  // Multiplier operands: sign-extend only the operands the op treats as signed.
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
  assign mul_a_ext = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) ?
                     {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
  assign mul_b_ext = (op_q == OP_MULH) ?
                     {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
  assign prod      = mul_a_ext * mul_b_ext;

  // One restoring-divide step: bring in the next dividend bit, try to subtract.
  logic [XLEN:0] shifted, trial;
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // State and datapath registers; reset clears everything including RESULT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; abort overrides everything and returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!bus.start)                       state_d = S_IDLE;
        else if (in_mul)                      state_d = S_MUL;
        else if (in_div && !in_zero && !in_ovf) state_d = S_DIV;
        else                                  state_d = S_DONE;
      end
      S_MUL:   state_d = (cnt_q == '0) ? S_DONE : S_MUL;
      S_DIV:   state_d = (cnt_q == '0) ? S_FIX : S_DIV;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) state_d = S_IDLE;
  end

  // Datapath updates: operand latch, multiply/divide progress, result write.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    cnt_d    = cnt_q;
    if (!bus.abort) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start && in_idle) begin
            op_d    = bus.select;
            a_d     = bus.data1;
            b_d     = bus.data2;
            cnt_d   = in_mul ? MUL_CNT_INIT : DIV_CNT_INIT;
            quo_d   = (in_signed && bus.data1[XLEN-1]) ? -bus.data1 : bus.data1;
            dvs_d   = (in_signed && bus.data2[XLEN-1]) ? -bus.data2 : bus.data2;
            rem_d   = '0;
            q_neg_d = in_signed && (bus.data1[XLEN-1] ^ bus.data2[XLEN-1]);
            r_neg_d = in_signed && bus.data1[XLEN-1];
            // Short-circuit cases complete on the accepting edge.
            if (!in_mul) begin
              if (!in_div)      result_d = '0;
              else if (in_zero) result_d = in_quo ? '1 : bus.data1;
              else if (in_ovf)  result_d = in_quo ? bus.data1 : '0;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0)
            result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          else
            cnt_d = cnt_q - CW'(1);
        end
        S_DIV: begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
        S_FIX: begin
          if ((op_q == OP_DIV) || (op_q == OP_DIVU))
            result_d = q_neg_q ? -quo_q : quo_q;
          else
            result_d = r_neg_q ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state.
  always_comb begin
    bus.busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    bus.valid  = (state_q == S_DONE);
    bus.result = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32, MUL_CYCLES=2).
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .MUL_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour from native 64-bit / signed arithmetic.
  function automatic logic [31:0] ref_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (sel)
      OP_MUL:    begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      OP_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      OP_MULHSU: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      OP_DIV:  if (b == 0) return 32'hFFFFFFFF;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
               else return sa / sb;
      OP_REM:  if (b == 0) return a;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
               else return sa % sb;
      OP_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (sel >= OP_MUL && sel <= OP_MULHU) return 3;
    if (sel < OP_DIV || sel > OP_REMU) return 1;
    if (b == 0) return 1;
    if ((sel == OP_DIV || sel == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  // Issue one op, scramble inputs after acceptance, wait for VALID, compare.
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input int exp_lat, input bit check_pulse);
    int lat;
    int busy_n;
    logic [31:0] want;
    exp_q.push_back(expv);
    bus.select = sel;
    bus.data1  = a;
    bus.data2  = b;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.data1  = $urandom;
    bus.data2  = $urandom;
    bus.select = 5'($urandom);
    lat = 1;
    busy_n = 0;
    while (!bus.valid && lat < 100) begin
      busy_n += bus.busy ? 1 : 0;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.valid) begin
      check_val("valid_timeout", 32'(bus.valid), 32'h1);
      void'(exp_q.pop_front());
      return;
    end
    want = exp_q.pop_front();
    $display("op sel=%b a=%h b=%h result=%h lat=%0d busy=%0d", sel, a, b, bus.result, lat, busy_n);
    check_val("result", bus.result, want);
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
    last_result = want;
    if (check_pulse) begin
      @(posedge clk); #1;
      check_val("valid_pulse", 32'(bus.valid), 32'h0);
      check_val("result_hold", bus.result, want);
    end
  endtask

  initial begin
    int vcount;
    logic [4:0] sel;
    logic [31:0] a, b;
    logic [4:0] sel_tab [8];
    sel_tab = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.select = '0; bus.data1 = '0; bus.data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_result", bus.result, 32'h0);
    check_val("reset_busy", 32'(bus.busy), 32'h0);
    check_val("reset_valid", 32'(bus.valid), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 1);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1);
    run_op(OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1);
    run_op(OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 1, 1);
    run_op(OP_REMU,  32'd100,      32'd0,        32'd100,      1, 1);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    run_op(OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 1);
    run_op(OP_MULHSU,32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3, 1);
    run_op(OP_MULH,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 3, 1);
    run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1);
    run_op(OP_REM,   32'd7,        32'hFFFFFFFE, 32'd1,        34, 1);
    run_op(OP_DIVU,  32'd100,      32'd7,        32'd14,       34, 1);
    run_op(OP_REMU,  32'd100,      32'd7,        32'd2,        34, 1);
    run_op(5'b00000, 32'd9,        32'd9,        32'h0,        1, 1);

    // Abort mid-divide: no VALID, RESULT retains previous value
    run_op(OP_MUL, 32'd11, 32'd13, 32'd143, 3, 1);
    bus.select = OP_DIV; bus.data1 = 32'd1000; bus.data2 = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_val("abort_busy_before", 32'(bus.busy), 32'h1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_val("abort_busy_after", 32'(bus.busy), 32'h0);
    check_val("abort_result", bus.result, last_result);
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      vcount += bus.valid ? 1 : 0;
    end
    check_val("abort_no_valid", 32'(vcount), 32'h0);
    $display("op abort during DIV 1000/3 result=%h", bus.result);

    // Abort beats start on the same edge
    bus.select = OP_MUL; bus.data1 = 32'd2; bus.data2 = 32'd2; bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check_val("abort_vs_start_busy", 32'(bus.busy), 32'h0);
    check_val("abort_vs_start_valid", 32'(bus.valid), 32'h0);
    $display("op start+abort same edge busy=%0b", bus.busy);

    run_op(OP_MUL, 32'd6, 32'd7, 32'd42, 3, 1);

    // Back-to-back: second START issued in the DONE cycle of the first
    run_op(OP_MUL, 32'd2, 32'd9, 32'd18, 3, 0);
    run_op(OP_MUL, 32'd3, 32'd5, 32'd15, 3, 1);

    // Reset mid-divide clears everything
    bus.select = OP_DIVU; bus.data1 = 32'd1000; bus.data2 = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("midreset_result", bus.result, 32'h0);
    check_val("midreset_busy", 32'(bus.busy), 32'h0);
    check_val("midreset_valid", 32'(bus.valid), 32'h0);
    $display("op reset during DIVU result=%h", bus.result);
    reset = 1'b1;
    @(posedge clk); #1;

    // Randomised ops with corner-biased operands
    for (int i = 0; i < 24; i++) begin
      sel = sel_tab[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0:       a = 32'h80000000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(sel, a, b, ref_op(sel, a, b), ref_latency(sel, a, b), 1);
    end

    check_val("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
